// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, RUN/PAUSE/ADJUST mode FSM, 1 Hz tick and digit-edit sequencing
// for the MM:SS stopwatch counter.
module stopwatch_ctrl #(
   parameter int DB_CYCLES = 1_000_000,
   parameter int TICK_DIV  = 100_000_000,
   parameter int BLINK_DIV = 20_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_pause,
   input  logic        btn_clear,
   input  logic        btn_adj,
   input  logic        btn_sel,
   input  logic        btn_inc,
   input  logic [15:0] cur_digits,
   output logic        tick_en,
   output logic        paused,
   output logic        adj,
   output logic [2:0]  adj_sel,
   output logic [3:0]  adj_val,
   output logic        set_strobe,
   output logic        clr,
   output logic        blink
);
   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int TW  = $clog2(TICK_DIV + 1);
   localparam int BW  = $clog2(BLINK_DIV + 1);
   typedef enum logic [1:0] {RUN, PAUSE, ADJUST} state_t;
   state_t state, state_n;
   logic [4:0] raw, sync1, sync2, deb, deb_d, press;
   logic [DBW-1:0] db_cnt [5];
   logic [TW-1:0] tick_cnt;
   logic [BW-1:0] blink_cnt;
   logic p_clr, p_adj, p_pause, p_sel, p_inc, enter, set_pend, tick_wrap;
   logic [2:0] load_sel;
   logic [3:0] load_raw, load_lim, load_val, inc_lim, inc_val;
   // bit order: 0 clear, 1 adj, 2 pause, 3 sel, 4 inc (also press priority, low index wins)
   assign raw = {btn_inc, btn_sel, btn_pause, btn_adj, btn_clear};
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_d <= deb;
         for (int i = 0; i < 5; i++) begin
            if (sync2[i] == deb[i]) db_cnt[i] <= '0;
            else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
               db_cnt[i] <= '0;
               deb[i]    <= sync2[i];
            end else db_cnt[i] <= db_cnt[i] + 1'b1;
         end
      end
   end
   assign press   = deb & ~deb_d;
   assign p_clr   = press[0];
   assign p_adj   = press[1] & ~press[0];
   assign p_pause = press[2] & ~|press[1:0];
   assign p_sel   = press[3] & ~|press[2:0];
   assign p_inc   = press[4] & ~|press[3:0];
   always_comb begin
      state_n = state;
      if (p_adj) state_n = (state == ADJUST) ? PAUSE : ADJUST;
      else if (p_pause && state != ADJUST) state_n = (state == RUN) ? PAUSE : RUN;
   end
   assign enter     = (state_n == ADJUST) && (state != ADJUST);
   assign load_sel  = (state != ADJUST || adj_sel == 3'd0) ? 3'd3 : adj_sel - 3'd1;
   assign load_raw  = cur_digits[{load_sel[1:0], 2'b00} +: 4];
   assign load_lim  = (load_sel == 3'd1) ? 4'd5 : 4'd9;
   assign load_val  = (load_raw > load_lim) ? load_lim : load_raw;
   assign inc_lim   = (adj_sel == 3'd1) ? 4'd5 : 4'd9;
   assign inc_val   = (adj_val >= inc_lim) ? 4'd0 : adj_val + 4'd1;
   assign tick_wrap = tick_cnt == TW'(TICK_DIV - 1);
   assign tick_en   = (state == RUN) && tick_wrap;
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= PAUSE;
         paused     <= 1'b1;
         adj        <= 1'b0;
         adj_sel    <= 3'd5;
         adj_val    <= 4'd0;
         set_pend   <= 1'b0;
         set_strobe <= 1'b0;
         clr        <= 1'b0;
         blink      <= 1'b0;
         tick_cnt   <= '0;
         blink_cnt  <= '0;
      end else begin
         state      <= state_n;
         paused     <= state_n != RUN;
         adj        <= state_n == ADJUST;
         clr        <= p_clr;
         set_pend   <= p_inc && state == ADJUST;
         set_strobe <= set_pend;
         // tick phase is held, not cleared, outside RUN
         tick_cnt   <= p_clr ? '0 : (state != RUN) ? tick_cnt : tick_wrap ? '0 : tick_cnt + 1'b1;
         adj_sel    <= (state_n != ADJUST) ? 3'd5 : (enter || p_sel) ? load_sel : adj_sel;
         adj_val    <= (state_n != ADJUST) ? 4'd0 : (enter || p_sel) ? load_val :
                       p_clr ? 4'd0 : p_inc ? inc_val : adj_val;
         if (state_n != ADJUST || enter) begin
            blink     <= state_n == ADJUST;
            blink_cnt <= '0;
         end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink     <= ~blink;
            blink_cnt <= '0;
         end else blink_cnt <= blink_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of the stopwatch mode controller with short debounce/tick/blink periods.
module tb_stopwatch_ctrl;
   localparam int CLR = 0, ADJ = 1, PAU = 2, SEL = 3, INC = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic [4:0] btn = '0;
   logic [15:0] cur_digits = '0;
   logic tick_en, paused, adj, set_strobe, clr, blink;
   logic [2:0] adj_sel;
   logic [3:0] adj_val;
   int checks = 0, errors = 0;

   stopwatch_ctrl #(.DB_CYCLES(4), .TICK_DIV(10), .BLINK_DIV(8)) dut (
      .clk(clk), .rst(rst), .btn_pause(btn[PAU]), .btn_clear(btn[CLR]), .btn_adj(btn[ADJ]),
      .btn_sel(btn[SEL]), .btn_inc(btn[INC]), .cur_digits(cur_digits), .tick_en(tick_en),
      .paused(paused), .adj(adj), .adj_sel(adj_sel), .adj_val(adj_val),
      .set_strobe(set_strobe), .clr(clr), .blink(blink));

   always #5 clk = ~clk;

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({tick_en, paused, adj, adj_sel, adj_val, set_strobe, clr, blink} !== 13'b0_1_0_101_0000_000) begin
         errors++;
         $display("FAIL reset_outputs got %b exp 0_1_0_101_0000_000",
                  {tick_en, paused, adj, adj_sel, adj_val, set_strobe, clr, blink});
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({tick_en, paused, adj_sel} !== 5'b0_1_101) begin
         errors++; $display("FAIL idle_after_reset got %b exp 0_1_101", {tick_en, paused, adj_sel});
      end
   endtask

   task automatic test_run_ticks;
      int n;
      btn[PAU] = 1'b1;
      n = 0;
      while (paused && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n !== 7) begin errors++; $display("FAIL press_latency got %0d exp 7", n); end
      btn[PAU] = 1'b0;
      checks++;
      if ({tick_en, adj_sel} !== 4'b0_101) begin
         errors++; $display("FAIL run_entry got %b exp 0_101", {tick_en, adj_sel});
      end
      n = 1;
      while (!tick_en && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (n !== 10) begin errors++; $display("FAIL first_tick got %0d exp 10", n); end
      n = 0;
      do begin @(negedge clk); n++; end while (!tick_en && n < 30);
      checks++;
      if (n !== 10 || paused !== 1'b0) begin
         errors++; $display("FAIL tick_period got %0d paused %b exp 10 paused 0", n, paused);
      end
   endtask

   task automatic test_pause_phase;
      int n, ticks;
      @(negedge clk);
      btn[PAU] = 1'b1;
      n = 0;
      while (!paused && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n !== 7) begin errors++; $display("FAIL pause_entry got %0d exp 7", n); end
      btn[PAU] = 1'b0;
      ticks = 0;
      repeat (50) begin @(negedge clk); if (tick_en) ticks++; end
      checks++;
      if (ticks !== 0) begin errors++; $display("FAIL ticks_in_pause got %0d exp 0", ticks); end
      btn[PAU] = 1'b1;
      n = 0;
      while (paused && n < 20) begin @(negedge clk); n++; end
      btn[PAU] = 1'b0;
      n = 1;
      while (!tick_en && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (n !== 3) begin errors++; $display("FAIL resume_phase got %0d exp 3", n); end
   endtask

   task automatic test_bounce;
      int changes;
      logic prev;
      repeat (12) @(negedge clk);
      changes = 0;
      prev = paused;
      btn[PAU] = 1'b1; @(negedge clk);
      btn[PAU] = 1'b0; @(negedge clk);
      btn[PAU] = 1'b1;
      repeat (15) begin @(negedge clk); if (paused !== prev) changes++; prev = paused; end
      btn[PAU] = 1'b0;
      repeat (15) begin @(negedge clk); if (paused !== prev) changes++; prev = paused; end
      checks++;
      if (changes !== 1 || paused !== 1'b1) begin
         errors++; $display("FAIL bounce got %0d changes paused %b exp 1 paused 1", changes, paused);
      end
   endtask

   task automatic sel_press(input logic [2:0] exp_sel, input logic [3:0] exp_val);
      int n;
      logic [2:0] old;
      old = adj_sel;
      btn[SEL] = 1'b1;
      n = 0;
      while (adj_sel === old && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (adj_sel !== exp_sel || adj_val !== exp_val) begin
         errors++; $display("FAIL sel_press got sel %0d val %0d exp sel %0d val %0d", adj_sel, adj_val, exp_sel, exp_val);
      end
      btn[SEL] = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic inc_press(input logic [3:0] exp_val);
      int n;
      logic [3:0] old;
      old = adj_val;
      btn[INC] = 1'b1;
      n = 0;
      while (adj_val === old && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (adj_val !== exp_val || set_strobe !== 1'b0) begin
         errors++; $display("FAIL inc_value got val %0d strobe %b exp val %0d strobe 0", adj_val, set_strobe, exp_val);
      end
      @(negedge clk);
      checks++;
      if (set_strobe !== 1'b1) begin errors++; $display("FAIL strobe_high got %b exp 1", set_strobe); end
      @(negedge clk);
      checks++;
      if (set_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width got %b exp 0", set_strobe); end
      btn[INC] = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic adj_toggle(input logic exp_adj);
      int n;
      btn[ADJ] = 1'b1;
      n = 0;
      while (adj !== exp_adj && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (adj !== exp_adj) begin errors++; $display("FAIL adj_toggle got %b exp %b", adj, exp_adj); end
   endtask

   task automatic test_adjust;
      cur_digits = 16'h0259;
      adj_toggle(1'b1);
      checks++;
      if ({adj_sel, adj_val, blink, paused} !== 9'b011_0000_1_1) begin
         errors++; $display("FAIL adj_entry got %b exp 011_0000_1_1", {adj_sel, adj_val, blink, paused});
      end
      repeat (7) @(negedge clk);
      checks++;
      if (blink !== 1'b1) begin errors++; $display("FAIL blink_hold got %b exp 1", blink); end
      @(negedge clk);
      checks++;
      if (blink !== 1'b0) begin errors++; $display("FAIL blink_toggle got %b exp 0", blink); end
      btn[ADJ] = 1'b0;
      repeat (12) @(negedge clk);
      sel_press(3'd2, 4'd2);
      sel_press(3'd1, 4'd5);
      inc_press(4'd0);
      sel_press(3'd0, 4'd9);
      inc_press(4'd0);
      cur_digits = 16'hC259;
      sel_press(3'd3, 4'd9);
      adj_toggle(1'b0);
      checks++;
      if ({adj_sel, paused, blink} !== 5'b101_1_0) begin
         errors++; $display("FAIL adj_exit got %b exp 101_1_0", {adj_sel, paused, blink});
      end
      btn[ADJ] = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_clear_priority;
      int n;
      btn[PAU] = 1'b1;
      n = 0;
      while (paused && n < 20) begin @(negedge clk); n++; end
      btn[PAU] = 1'b0;
      repeat (12) @(negedge clk);
      btn[CLR] = 1'b1;
      btn[PAU] = 1'b1;
      n = 0;
      while (!clr && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (clr !== 1'b1 || paused !== 1'b0) begin
         errors++; $display("FAIL clear_in_run got clr %b paused %b exp clr 1 paused 0", clr, paused);
      end
      @(negedge clk);
      checks++;
      if (clr !== 1'b0) begin errors++; $display("FAIL clr_width got %b exp 0", clr); end
      n = 2;
      while (!tick_en && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (n !== 10 || paused !== 1'b0) begin
         errors++; $display("FAIL tick_after_clear got %0d paused %b exp 10 paused 0", n, paused);
      end
      btn[CLR] = 1'b0;
      btn[PAU] = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_rst_mid_edit;
      int n, strobes;
      cur_digits = 16'h7259;
      adj_toggle(1'b1);
      checks++;
      if (adj_val !== 4'd7) begin errors++; $display("FAIL adj_load got %0d exp 7", adj_val); end
      btn[ADJ] = 1'b0;
      repeat (12) @(negedge clk);
      btn[CLR] = 1'b1;
      n = 0;
      while (!clr && n < 20) begin @(negedge clk); n++; end
      checks++;
      if ({clr, adj, adj_val} !== 6'b1_1_0000) begin
         errors++; $display("FAIL clear_in_adj got %b exp 1_1_0000", {clr, adj, adj_val});
      end
      btn[CLR] = 1'b0;
      repeat (12) @(negedge clk);
      btn[INC] = 1'b1;
      n = 0;
      while (adj_val === 4'd0 && n < 20) begin @(negedge clk); n++; end
      rst = 1'b1;
      checks++;
      if (adj_val !== 4'd1) begin errors++; $display("FAIL inc_before_rst got %0d exp 1", adj_val); end
      strobes = 0;
      repeat (3) begin @(negedge clk); if (set_strobe) strobes++; end
      btn[INC] = 1'b0;
      rst = 1'b0;
      repeat (20) begin @(negedge clk); if (set_strobe) strobes++; end
      checks++;
      if (strobes !== 0) begin errors++; $display("FAIL strobe_after_rst got %0d exp 0", strobes); end
      checks++;
      if ({paused, adj, adj_sel} !== 5'b1_0_101) begin
         errors++; $display("FAIL rst_mid_edit got %b exp 1_0_101", {paused, adj, adj_sel});
      end
   endtask

   initial begin
      test_reset();
      test_run_ticks();
      test_pause_phase();
      test_bounce();
      test_adjust();
      test_clear_priority();
      test_rst_mid_edit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
